// File: rtl/bus_subsystem_arbiter.sv
// bus_subsystem_arbiter: grants the shared host bus to one subsystem FSM by decoded ID,
// with a handshake watchdog, release tracking and error recovery.
module bus_subsystem_arbiter #(
   parameter int NUM_SUBSYSTEMS = 5,
   parameter int ID_WIDTH       = 3,
   parameter int ID_LSB         = 8,
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      bus_request,
   input  logic [31:0]               cmd_word,
   input  logic                      handshake_1,
   input  logic [NUM_SUBSYSTEMS-1:0] subsystem_idle,
   output logic [NUM_SUBSYSTEMS-1:0] subsystem_enable,
   output logic [ID_WIDTH-1:0]       active_id,
   output logic                      busy,
   output logic                      bus_error,
   output logic [1:0]                error_code,
   output logic [CNT_WIDTH-1:0]      transaction_count
);
   typedef enum logic [2:0] {S_IDLE, S_CHECK, S_GRANT, S_ACTIVE, S_RELEASE, S_ERROR} state_t;
   localparam int NID = 2 ** ID_WIDTH;
   localparam int WD_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES - 1);
   state_t state;
   logic hs_prev;
   logic [WD_W-1:0] watchdog, wd_next;
   logic [NID-1:0] idle_ext;
   logic target_idle, valid_id, timeout;
   logic [NUM_SUBSYSTEMS-1:0] grant_vec;
   // idle vector padded to the full ID space so an out-of-range ID never indexes past it
   assign idle_ext = NID'(subsystem_idle);
   assign target_idle = idle_ext[active_id];
   assign valid_id = {1'b0, active_id} < (ID_WIDTH + 1)'(NUM_SUBSYSTEMS);
   assign grant_vec = NUM_SUBSYSTEMS'(1) << active_id;
   assign wd_next = (handshake_1 != hs_prev) ? '0 : watchdog + 1'b1;
   assign timeout = wd_next == WD_MAX;
   assign busy = state != S_IDLE;
   assign bus_error = state == S_ERROR;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state             <= S_IDLE;
         subsystem_enable  <= '0;
         active_id         <= '0;
         error_code        <= 2'b00;
         transaction_count <= '0;
         watchdog          <= '0;
         hs_prev           <= 1'b0;
      end else begin
         hs_prev <= handshake_1;
         case (state)
            S_IDLE: if (bus_request) begin
               active_id <= cmd_word[ID_LSB +: ID_WIDTH];
               state     <= S_CHECK;
            end
            S_CHECK: begin
               error_code <= !valid_id ? 2'b01 : !target_idle ? 2'b11 : 2'b00;
               state      <= (valid_id && target_idle) ? S_GRANT : S_ERROR;
            end
            S_GRANT: begin
               subsystem_enable <= grant_vec;
               watchdog         <= '0;
               state            <= S_ACTIVE;
            end
            S_ACTIVE: begin
               watchdog <= wd_next;
               if (!bus_request) begin
                  subsystem_enable <= '0;
                  state            <= S_RELEASE;
               end else if (timeout) begin
                  subsystem_enable <= '0;
                  error_code       <= 2'b10;
                  state            <= S_ERROR;
               end
            end
            S_RELEASE: begin
               watchdog <= wd_next;
               if (target_idle) begin
                  transaction_count <= transaction_count + 1'b1;
                  state             <= S_IDLE;
               end else if (timeout) begin
                  error_code <= 2'b10;
                  state      <= S_ERROR;
               end
            end
            S_ERROR: if (!bus_request) state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_bus_subsystem_arbiter.sv
// tb_bus_subsystem_arbiter: directed vector table plus hand sequences for
// latency, timeout, release priority, counter wrap and async reset.
module tb_bus_subsystem_arbiter;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic bus_request = 1'b0;
   logic [31:0] cmd_word = '0;
   logic handshake_1 = 1'b0;
   logic [4:0] subsystem_idle = 5'b11111;
   logic [4:0] subsystem_enable;
   logic [2:0] active_id;
   logic busy, bus_error;
   logic [1:0] error_code;
   logic [3:0] transaction_count;
   logic [3:0] exp_count = '0;
   int n_cmp = 0;
   int n_err = 0;

   typedef struct packed {
      logic [31:0] cmd;
      logic [4:0]  idle;
      logic [4:0]  en;
      logic        err;
      logic [1:0]  code;
   } vec_t;
   vec_t vecs [10];

   bus_subsystem_arbiter #(
      .NUM_SUBSYSTEMS(5), .ID_WIDTH(3), .ID_LSB(8), .TIMEOUT_CYCLES(16), .CNT_WIDTH(4)
   ) dut (
      .clk(clk), .reset(reset), .bus_request(bus_request), .cmd_word(cmd_word),
      .handshake_1(handshake_1), .subsystem_idle(subsystem_idle),
      .subsystem_enable(subsystem_enable), .active_id(active_id), .busy(busy),
      .bus_error(bus_error), .error_code(error_code), .transaction_count(transaction_count)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "time limit");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic start(input logic [31:0] cmd, input logic [4:0] idle);
      cmd_word = cmd;
      subsystem_idle = idle;
      bus_request = 1'b1;
   endtask

   task automatic do_txn();
      start(32'h0000_0000, 5'b11111);
      tick(3);
      bus_request = 1'b0;
      tick(2);
      exp_count++;
   endtask

   initial begin
      vecs[0] = '{32'h0000_0200, 5'b11111, 5'b00100, 1'b0, 2'b00};
      vecs[1] = '{32'h0000_0600, 5'b11111, 5'b00000, 1'b1, 2'b01};
      vecs[2] = '{32'h0000_0100, 5'b11101, 5'b00000, 1'b1, 2'b11};
      vecs[3] = '{32'h0000_0000, 5'b11111, 5'b00001, 1'b0, 2'b00};
      vecs[4] = '{32'h0000_0400, 5'b11111, 5'b10000, 1'b0, 2'b00};
      vecs[5] = '{32'h0000_0500, 5'b11111, 5'b00000, 1'b1, 2'b01};
      vecs[6] = '{32'h0000_0700, 5'b11111, 5'b00000, 1'b1, 2'b01};
      vecs[7] = '{32'hFFFF_F9FF, 5'b11111, 5'b00010, 1'b0, 2'b00};
      vecs[8] = '{32'h0000_0300, 5'b10111, 5'b00000, 1'b1, 2'b11};
      vecs[9] = '{32'h0000_0300, 5'b01000, 5'b01000, 1'b0, 2'b00};

      tick(2);
      reset = 1'b0;
      check("rst_en", subsystem_enable, 0);
      check("rst_busy", busy, 0);
      check("rst_err", bus_error, 0);
      check("rst_code", error_code, 0);
      check("rst_id", active_id, 0);
      check("rst_cnt", transaction_count, 0);

      // normal grant, cmd_word change after latch must be ignored
      start(32'h0000_0200, 5'b11111);
      tick();
      cmd_word = 32'h0000_0400;
      check("norm_busy_e0", busy, 1);
      tick();
      check("norm_en_e1", subsystem_enable, 0);
      tick();
      check("norm_en_e2", subsystem_enable, 5'b00100);
      check("norm_id", active_id, 2);
      subsystem_idle = 5'b11011;
      bus_request = 1'b0;
      tick();
      check("norm_rel_en", subsystem_enable, 0);
      check("norm_rel_busy", busy, 1);
      tick();
      check("norm_wait_busy", busy, 1);
      check("norm_wait_cnt", transaction_count, 0);
      subsystem_idle = 5'b11111;
      tick();
      exp_count++;
      check("norm_done_busy", busy, 0);
      check("norm_done_en", subsystem_enable, 0);
      check("norm_done_cnt", transaction_count, exp_count);

      // request dropped during CHECK still gives a one-cycle enable
      start(32'h0000_0200, 5'b11111);
      tick();
      bus_request = 1'b0;
      tick(2);
      check("drop_en_pulse", subsystem_enable, 5'b00100);
      tick();
      check("drop_en_off", subsystem_enable, 0);
      tick();
      exp_count++;
      check("drop_busy", busy, 0);
      check("drop_cnt", transaction_count, exp_count);

      for (int i = 0; i < 10; i++) begin
         start(vecs[i].cmd, vecs[i].idle);
         tick(2);
         check($sformatf("v%0d_en_e1", i), subsystem_enable, 0);
         tick();
         check($sformatf("v%0d_en", i), subsystem_enable, vecs[i].en);
         check($sformatf("v%0d_err", i), bus_error, vecs[i].err);
         check($sformatf("v%0d_code", i), error_code, vecs[i].code);
         check($sformatf("v%0d_busy", i), busy, 1);
         bus_request = 1'b0;
         tick(2);
         if (!vecs[i].err) exp_count++;
         check($sformatf("v%0d_idle_busy", i), busy, 0);
         check($sformatf("v%0d_idle_err", i), bus_error, 0);
         check($sformatf("v%0d_hold_code", i), error_code, vecs[i].code);
         check($sformatf("v%0d_cnt", i), transaction_count, exp_count);
      end

      // static handshake: error exactly 15 cycles after entering ACTIVE
      start(32'h0000_0000, 5'b11111);
      tick(17);
      check("to_pre_en", subsystem_enable, 5'b00001);
      check("to_pre_err", bus_error, 0);
      tick();
      check("to_err", bus_error, 1);
      check("to_code", error_code, 2'b10);
      check("to_en", subsystem_enable, 0);
      tick(3);
      check("to_stay_err", bus_error, 1);
      bus_request = 1'b0;
      tick();
      check("to_exit_busy", busy, 0);
      check("to_cnt", transaction_count, exp_count);

      // handshake toggling every 10 cycles keeps the watchdog clear
      start(32'h0000_0000, 5'b11111);
      for (int i = 0; i < 60; i++) begin
         if (i % 10 == 9) handshake_1 = ~handshake_1;
         tick();
      end
      check("tog_err", bus_error, 0);
      check("tog_en", subsystem_enable, 5'b00001);
      bus_request = 1'b0;
      tick(2);
      exp_count++;
      check("tog_cnt", transaction_count, exp_count);

      // release on the same cycle the watchdog expires wins over timeout
      start(32'h0000_0000, 5'b11111);
      tick(17);
      bus_request = 1'b0;
      tick();
      check("sim_err", bus_error, 0);
      check("sim_busy", busy, 1);
      check("sim_en", subsystem_enable, 0);
      tick();
      exp_count++;
      check("sim_busy_done", busy, 0);
      check("sim_cnt", transaction_count, exp_count);

      // async reset mid-ACTIVE
      start(32'h0000_0100, 5'b11111);
      tick(3);
      check("ar_en_pre", subsystem_enable, 5'b00010);
      #2 reset = 1'b1;
      #1;
      check("ar_en", subsystem_enable, 0);
      check("ar_busy", busy, 0);
      check("ar_id", active_id, 0);
      check("ar_cnt", transaction_count, 0);
      bus_request = 1'b0;
      tick();
      reset = 1'b0;
      exp_count = '0;

      // counter wrap
      while (exp_count != 4'd15) do_txn();
      check("wrap_15", transaction_count, 15);
      do_txn();
      check("wrap_0", transaction_count, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
